// File: rtl/uart_tx.sv
// uart_tx: serialises one parallel word per handshake into a start/data/parity/stop frame.
// Each bit lasts the Prescale value latched when the word is accepted.
module uart_tx #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [width-1:0] P_Data,
    input  logic             Data_valid,
    input  logic             Parity_EN,
    input  logic             Parity_type,
    input  logic [4:0]       Prescale,
    output logic             TX_OUT,
    output logic             Busy
);
    localparam int BW = width > 1 ? $clog2(width) : 1;
    localparam logic [BW-1:0] LAST = BW'(width - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [4:0] edge_cnt, edge_n, pre_r;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [width-1:0] data_r;
    logic par_en_r, par_type_r, accept, bit_end, tx_n;
    assign accept = state == IDLE && Data_valid && !Busy;
    assign bit_end = edge_cnt == pre_r - 5'd1;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? START : IDLE;
            START:   state_n = bit_end ? DATA : START;
            DATA:    state_n = bit_end && bit_cnt == LAST ? (par_en_r ? PARITY : STOP) : DATA;
            PARITY:  state_n = bit_end ? STOP : PARITY;
            STOP:    state_n = bit_end ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
        edge_n = (state_n != state || state == IDLE || bit_end) ? 5'd0 : edge_cnt + 5'd1;
        bit_n = state_n != state ? '0 : (state == DATA && bit_end) ? bit_cnt + BW'(1) : bit_cnt;
        // line value is computed for the upcoming state so TX_OUT can be a plain register
        tx_n = state_n == START ? 1'b0 :
               state_n == DATA ? data_r[bit_n] :
               state_n == PARITY ? (^data_r) ^ par_type_r : 1'b1;
    end
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            edge_cnt <= '0;
            bit_cnt <= '0;
            TX_OUT <= 1'b1;
            Busy <= 1'b0;
        end else begin
            state <= state_n;
            edge_cnt <= edge_n;
            bit_cnt <= bit_n;
            TX_OUT <= tx_n;
            Busy <= state_n != IDLE;
        end
    end
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            data_r <= '0;
            par_en_r <= 1'b0;
            par_type_r <= 1'b0;
            pre_r <= '0;
        end else if (accept) begin
            data_r <= P_Data;
            par_en_r <= Parity_EN;
            par_type_r <= Parity_type;
            pre_r <= Prescale == 5'd0 ? 5'd1 : Prescale;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-queue model checked every cycle, plus literal frame captures.
module tb_uart_tx;
    logic CLK = 0, Reset = 1, Data_valid = 0, Parity_EN = 0, Parity_type = 0;
    logic [7:0] P_Data = 0;
    logic [4:0] Prescale = 1;
    logic TX_OUT, Busy;
    int compared = 0, mismatched = 0;
    logic exp_tx = 1, exp_busy = 0;
    bit q[$];
    int mp;

    always #5 CLK = ~CLK;

    uart_tx #(.width(8)) dut (
        .CLK(CLK), .Reset(Reset), .P_Data(P_Data), .Data_valid(Data_valid),
        .Parity_EN(Parity_EN), .Parity_type(Parity_type), .Prescale(Prescale),
        .TX_OUT(TX_OUT), .Busy(Busy)
    );

    // model: a request seen while idle queues the whole frame, one entry per cycle
    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            q.delete();
            exp_tx = 1;
            exp_busy = 0;
        end else if (q.size() > 0) begin
            exp_tx = q.pop_front();
            exp_busy = 1;
        end else if (Data_valid && !exp_busy) begin
            mp = Prescale == 0 ? 1 : int'(Prescale);
            for (int k = 0; k < mp; k++) q.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                for (int k = 0; k < mp; k++) q.push_back(P_Data[i]);
            if (Parity_EN)
                for (int k = 0; k < mp; k++) q.push_back((^P_Data) ^ Parity_type);
            for (int k = 0; k < mp; k++) q.push_back(1'b1);
            exp_tx = q.pop_front();
            exp_busy = 1;
        end else begin
            exp_tx = 1;
            exp_busy = 0;
        end
    end

    always @(negedge CLK) begin
        compared++;
        if (TX_OUT !== exp_tx || Busy !== exp_busy) begin
            mismatched++;
            $display("FAIL model_cycle t=%0t tx=%b busy=%b expected tx=%b busy=%b",
                     $time, TX_OUT, Busy, exp_tx, exp_busy);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    task automatic wait_busy();
        int w = 0;
        do begin
            @(negedge CLK);
            w++;
        end while (!Busy && w < 50);
        if (!Busy) chk("start_timeout", 32'(Busy), 32'd1);
    endtask

    task automatic capture(input int p, input int disturb, output logic [15:0] bits, output int n);
        bits = '0;
        n = 0;
        wait_busy();
        Data_valid = 0;
        while (Busy && n < 2000) begin
            if (n % p == 0 && n / p < 16) bits[n / p] = TX_OUT;
            if (n == disturb) begin
                P_Data = 8'h3C; Prescale = 2; Parity_EN = 1; Parity_type = 1; Data_valid = 1;
            end
            if (n == disturb + 3) Data_valid = 0;
            n++;
            @(negedge CLK);
        end
    endtask

    initial begin
        logic [15:0] bits;
        logic [21:0] s;
        int n;
        #1 Reset = 0;
        repeat (2) @(negedge CLK);
        chk("reset_tx", 32'(TX_OUT), 32'd1);
        chk("reset_busy", 32'(Busy), 32'd0);
        Reset = 1;
        @(negedge CLK);
        P_Data = 8'hA5; Parity_EN = 1; Parity_type = 0; Prescale = 8; Data_valid = 1;
        capture(8, -1, bits, n);
        chk("even_bits", 32'(bits), 32'b10101001010);
        chk("even_len", n, 88);
        chk("even_idle_tx", 32'(TX_OUT), 32'd1);
        Parity_type = 1; Data_valid = 1;
        capture(8, -1, bits, n);
        chk("odd_bits", 32'(bits), 32'b11101001010);
        chk("odd_len", n, 88);
        Parity_EN = 0; Data_valid = 1;
        capture(8, -1, bits, n);
        chk("nopar_bits", 32'(bits), 32'b1101001010);
        chk("nopar_len", n, 80);
        P_Data = 8'hFF; Prescale = 4; Parity_EN = 0; Parity_type = 0; Data_valid = 1;
        capture(4, 10, bits, n);
        chk("busy_drop_bits", 32'(bits), 32'b1111111110);
        chk("busy_drop_len", n, 40);
        repeat (10) @(negedge CLK);
        chk("busy_drop_idle", 32'(Busy), 32'd0);
        P_Data = 8'h01; Prescale = 1; Parity_EN = 0; Parity_type = 0; Data_valid = 1;
        wait_busy();
        for (int k = 0; k < 22; k++) begin
            s[k] = TX_OUT;
            if (k == 0) P_Data = 8'h80;
            if (k == 11) Data_valid = 0;
            @(negedge CLK);
        end
        chk("b2b_line", 32'(s), 32'b1110000000011000000010);
        repeat (3) @(negedge CLK);
        P_Data = 8'hA5; Prescale = 4; Data_valid = 1;
        wait_busy();
        Data_valid = 0;
        repeat (17) @(negedge CLK);
        chk("pre_reset_bit3", 32'(TX_OUT), 32'd0);
        #2 Reset = 0;
        #1;
        chk("async_reset_tx", 32'(TX_OUT), 32'd1);
        chk("async_reset_busy", 32'(Busy), 32'd0);
        @(negedge CLK);
        Reset = 1;
        repeat (20) @(negedge CLK);
        chk("post_reset_busy", 32'(Busy), 32'd0);
        chk("post_reset_tx", 32'(TX_OUT), 32'd1);
        P_Data = 8'h55; Prescale = 1; Parity_EN = 1; Parity_type = 0; Data_valid = 1;
        capture(1, -1, bits, n);
        chk("pre1_bits", 32'(bits), 32'b10010101010);
        chk("pre1_len", n, 11);
        Prescale = 0; Data_valid = 1;
        capture(1, -1, bits, n);
        chk("pre0_bits", 32'(bits), 32'b10010101010);
        chk("pre0_len", n, 11);
        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
